rat_hazard_unit: RTL and testbench

- Pipeline hazard controller for the pipelined RAT MCU.
- Tracks in-flight register writes in a shift-register scoreboard and drives the operand forwarding selects.
- Stalls on load-use hazards, flushes the fetch/decode shadow after a taken branch, and drains the pipeline before an interrupt vector is taken.
- Parametrised successor to the fixed single-select forwarding muxes of the current core: it generalises register-address width, forwarding depth and branch-shadow length.

---
 rtl/rat_hazard_unit.sv | 190 +++++++++++++++++++
 tb/tb_rat_hazard_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_hazard_unit.sv
// ---------------------------------------------------------------------------
// rat_hazard_unit
//
// Pipeline hazard controller for the pipelined RAT MCU.
//
// A shift-register scoreboard records every register write that leaves
// decode. Entry 1 is the execute stage and entry DEPTH is writeback.
// The scoreboard drives the rX/rY forwarding selects and detects load-use
// hazards. A down-counter holds FLUSH over the branch shadow. A three-state
// FSM drains the pipeline before the interrupt vector is taken.
//
// Parameters
//   REG_AW     register-file address width
//   DEPTH      number of post-decode stages tracked (1..7)
//   FLUSH_LEN  cycles FLUSH stays high after a taken branch (1..7)
//
// Ports
//   CLK, RESET          rising-edge clock, synchronous active-high reset
//   ID_*                decode-stage operand addresses, usage, write info
//   BRN_TAKEN           execute resolved a taken branch/call/ret/reti
//   INTR_REQ, INTR_EN   interrupt request level and enable flag
//   STALL, FLUSH        pipeline hold / bubble-insert controls
//   FWD_X_SEL/Y_SEL     operand source: 0 = register file, k = stage k
//   INTR_TAKE           one-cycle pulse that vectors to the interrupt
//   BUSY                at least one write is still in flight
// ---------------------------------------------------------------------------
module rat_hazard_unit #(
   parameter int  REG_AW    = 5,
   parameter int  DEPTH     = 2,
   parameter int  FLUSH_LEN = 2,
   localparam int SW        = $clog2(DEPTH + 32'sd1)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ID_VALID,
   input  logic [REG_AW-1:0] ID_ADDRX,
   input  logic [REG_AW-1:0] ID_ADDRY,
   input  logic              ID_USE_X,
   input  logic              ID_USE_Y,
   input  logic              ID_RF_WR,
   input  logic              ID_LATE,
   input  logic              BRN_TAKEN,
   input  logic              INTR_REQ,
   input  logic              INTR_EN,
   output logic              STALL,
   output logic              FLUSH,
   output logic [SW-1:0]     FWD_X_SEL,
   output logic [SW-1:0]     FWD_Y_SEL,
   output logic              INTR_TAKE,
   output logic              BUSY
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_TAKE  = 2'd2
   } intr_state_t;

   localparam logic [2:0]    FLUSH_INIT = 3'(FLUSH_LEN);
   localparam logic [SW-1:0] SEL_RF     = {SW{1'b0}};
   localparam logic [SW-1:0] SEL_STAGE1 = SW'(32'd1);

   // Scoreboard. A late result is ready once it reaches stage 2, so the
   // late flag only matters in entry 1 and is not carried further.
   logic [DEPTH:1]    sb_v_r;
   logic [REG_AW-1:0] sb_addr_r [1:DEPTH];
   logic              sb_late1_r;

   logic [2:0]        flush_cnt_r;
   intr_state_t       state_r;
   intr_state_t       state_s;

   logic              issue_s;
   logic              flush_s;
   logic              stall_s;
   logic              busy_s;
   logic              drain_s;
   logic              x_lu_s;
   logic              y_lu_s;
   logic [SW-1:0]     x_match_s;
   logic [SW-1:0]     y_match_s;

   assign busy_s  = |sb_v_r;
   assign drain_s = (state_r == ST_DRAIN);
   assign flush_s = BRN_TAKEN | (flush_cnt_r != 3'd0);

   // An unready match can only be the youngest entry holding a late result.
   assign x_lu_s  = (x_match_s == SEL_STAGE1) & sb_late1_r;
   assign y_lu_s  = (y_match_s == SEL_STAGE1) & sb_late1_r;

   // FLUSH wins over STALL so the PC is free to load the branch target.
   assign stall_s = ID_VALID & (x_lu_s | y_lu_s | drain_s) & ~flush_s;
   assign issue_s = ID_VALID & ID_RF_WR & ~stall_s & ~flush_s;

   // Youngest-match search: scanning oldest to youngest lets the lowest k win.
   always_comb begin
      x_match_s = SEL_RF;
      y_match_s = SEL_RF;
      for (int k = DEPTH; k > 32'sd0; k--) begin
         if (ID_USE_X && sb_v_r[k] && (sb_addr_r[k] == ID_ADDRX)) begin
            x_match_s = SW'(k);
         end else begin
            x_match_s = x_match_s;
         end
         if (ID_USE_Y && sb_v_r[k] && (sb_addr_r[k] == ID_ADDRY)) begin
            y_match_s = SW'(k);
         end else begin
            y_match_s = y_match_s;
         end
      end
   end

   // Scoreboard shift: entry k+1 takes entry k, and entry 1 takes the issue or a bubble.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sb_v_r     <= {DEPTH{1'b0}};
         sb_late1_r <= 1'b0;
         for (int k = DEPTH; k > 32'sd0; k--) begin
            sb_addr_r[k] <= {REG_AW{1'b0}};
         end
      end else begin
         for (int k = DEPTH; k > 32'sd1; k--) begin
            sb_v_r[k]    <= sb_v_r[k - 32'sd1];
            sb_addr_r[k] <= sb_addr_r[k - 32'sd1];
         end
         sb_v_r[1]    <= issue_s;
         sb_addr_r[1] <= ID_ADDRX;
         sb_late1_r   <= ID_LATE;
      end
   end

   // Branch-shadow counter: a taken branch (re)loads it, then it counts down to zero.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         flush_cnt_r <= 3'd0;
      end else if (BRN_TAKEN) begin
         flush_cnt_r <= FLUSH_INIT;
      end else if (flush_cnt_r != 3'd0) begin
         flush_cnt_r <= flush_cnt_r - 3'd1;
      end else begin
         flush_cnt_r <= 3'd0;
      end
   end

   // Interrupt FSM state register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Interrupt FSM next state. Losing the enable during drain aborts silently.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (INTR_REQ && INTR_EN) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (!INTR_EN) begin
               state_s = ST_IDLE;
            end else if (!busy_s && !flush_s && !BRN_TAKEN) begin
               state_s = ST_TAKE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_TAKE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   assign STALL     = stall_s;
   assign FLUSH     = flush_s;
   assign FWD_X_SEL = x_lu_s ? SEL_RF : x_match_s;
   assign FWD_Y_SEL = y_lu_s ? SEL_RF : y_match_s;
   assign INTR_TAKE = (state_r == ST_TAKE);
   assign BUSY      = busy_s;

endmodule

// File: tb/tb_rat_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_rat_hazard_unit
//
// Self-checking bench for rat_hazard_unit with DEPTH=2 and FLUSH_LEN=2.
// A table of per-cycle {inputs, expected outputs} records is applied one
// cycle per row. Expected outputs are queued when a row is driven, then
// popped and compared at the falling edge. Two hand-written sequences
// cover the interrupt latency and the enable-drop abort.
// ---------------------------------------------------------------------------
module tb_rat_hazard_unit;

   localparam int REG_AW    = 5;
   localparam int DEPTH     = 2;
   localparam int FLUSH_LEN = 2;
   localparam int SW        = 2;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   typedef struct packed {
      logic          stall;
      logic          flush;
      logic [SW-1:0] fx;
      logic [SW-1:0] fy;
      logic          take;
      logic          busy;
   } exp_t;

   typedef struct packed {
      logic              rst;
      logic              vld;
      logic [REG_AW-1:0] ax;
      logic [REG_AW-1:0] ay;
      logic              ux;
      logic              uy;
      logic              wr;
      logic              late;
      logic              brn;
      logic              ireq;
      logic              ien;
      logic              chk;
      exp_t              e;
   } vec_t;

   logic              CLK;
   logic              RESET;
   logic              ID_VALID;
   logic [REG_AW-1:0] ID_ADDRX;
   logic [REG_AW-1:0] ID_ADDRY;
   logic              ID_USE_X;
   logic              ID_USE_Y;
   logic              ID_RF_WR;
   logic              ID_LATE;
   logic              BRN_TAKEN;
   logic              INTR_REQ;
   logic              INTR_EN;
   logic              STALL;
   logic              FLUSH;
   logic [SW-1:0]     FWD_X_SEL;
   logic [SW-1:0]     FWD_Y_SEL;
   logic              INTR_TAKE;
   logic              BUSY;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   lat_q[$];
   int   checks = 0;
   int   errors = 0;

   rat_hazard_unit #(
      .REG_AW   (REG_AW),
      .DEPTH    (DEPTH),
      .FLUSH_LEN(FLUSH_LEN)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .ID_VALID (ID_VALID),
      .ID_ADDRX (ID_ADDRX),
      .ID_ADDRY (ID_ADDRY),
      .ID_USE_X (ID_USE_X),
      .ID_USE_Y (ID_USE_Y),
      .ID_RF_WR (ID_RF_WR),
      .ID_LATE  (ID_LATE),
      .BRN_TAKEN(BRN_TAKEN),
      .INTR_REQ (INTR_REQ),
      .INTR_EN  (INTR_EN),
      .STALL    (STALL),
      .FLUSH    (FLUSH),
      .FWD_X_SEL(FWD_X_SEL),
      .FWD_Y_SEL(FWD_Y_SEL),
      .INTR_TAKE(INTR_TAKE),
      .BUSY     (BUSY)
   );

   // Free-running clock, 10 time units per period.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Hard stop in case the main sequence ever stops advancing.
   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(
      input logic rst, vld,
      input logic [REG_AW-1:0] ax, ay,
      input logic ux, uy, wr, late, brn, ireq, ien, chk,
      input logic stall, flush,
      input logic [SW-1:0] fx, fy,
      input logic take, busy);
      vec_t v;
      v.rst  = rst;  v.vld  = vld;  v.ax  = ax;   v.ay   = ay;
      v.ux   = ux;   v.uy   = uy;   v.wr  = wr;   v.late = late;
      v.brn  = brn;  v.ireq = ireq; v.ien = ien;  v.chk  = chk;
      v.e.stall = stall; v.e.flush = flush; v.e.fx = fx; v.e.fy = fy;
      v.e.take  = take;  v.e.busy  = busy;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s [%0d]: got %0d expected %0d", nm, idx, act, expv);
      end
   endtask

   task automatic drive_idle();
      RESET = L; ID_VALID = L; ID_ADDRX = 5'd0; ID_ADDRY = 5'd0;
      ID_USE_X = L; ID_USE_Y = L; ID_RF_WR = L; ID_LATE = L;
      BRN_TAKEN = L; INTR_REQ = L; INTR_EN = L;
   endtask

   // Drive one row, compare at the falling edge, return just after the next rising edge.
   task automatic apply(input vec_t v, input int idx);
      exp_t ex;
      RESET = v.rst; ID_VALID = v.vld; ID_ADDRX = v.ax; ID_ADDRY = v.ay;
      ID_USE_X = v.ux; ID_USE_Y = v.uy; ID_RF_WR = v.wr; ID_LATE = v.late;
      BRN_TAKEN = v.brn; INTR_REQ = v.ireq; INTR_EN = v.ien;
      if (v.chk) exp_q.push_back(v.e);
      @(negedge CLK);
      if (v.chk) begin
         ex = exp_q.pop_front();
         chk("STALL",     idx, 8'(STALL),     8'(ex.stall));
         chk("FLUSH",     idx, 8'(FLUSH),     8'(ex.flush));
         chk("FWD_X_SEL", idx, 8'(FWD_X_SEL), 8'(ex.fx));
         chk("FWD_Y_SEL", idx, 8'(FWD_Y_SEL), 8'(ex.fy));
         chk("INTR_TAKE", idx, 8'(INTR_TAKE), 8'(ex.take));
         chk("BUSY",      idx, 8'(BUSY),      8'(ex.busy));
      end
      @(posedge CLK);
      #1;
   endtask

   // Main sequence: vector table, then the hand-written interrupt cases.
   initial begin
      int n;
      int pulses;
      int lat_exp;

      drive_idle();
      RESET = H;

      //              rst vld ax     ay     ux uy wr lt br rq en chk  stl fl fx    fy    tk bsy
      // reset with every input high, then clean outputs
      vecs.push_back(mk(H, H, 5'd31, 5'd31, H, H, H, H, H, H, H, L,   L, L, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(H, H, 5'd31, 5'd31, H, H, H, H, H, H, H, L,   L, L, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, L, 5'd0,  5'd0,  L, L, L, L, L, L, L, H,   L, L, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, H, 5'd0,  5'd0,  H, H, L, L, L, L, L, H,   L, L, 2'd0, 2'd0, L, L));
      // ALU back-to-back on r3: 1, then 2, then register file
      vecs.push_back(mk(L, H, 5'd3,  5'd0,  L, L, H, L, L, L, L, H,   L, L, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, H, 5'd3,  5'd0,  H, L, L, L, L, L, L, H,   L, L, 2'd1, 2'd0, L, H));
      vecs.push_back(mk(L, H, 5'd3,  5'd0,  H, L, L, L, L, L, L, H,   L, L, 2'd2, 2'd0, L, H));
      vecs.push_back(mk(L, H, 5'd3,  5'd0,  H, L, L, L, L, L, L, H,   L, L, 2'd0, 2'd0, L, L));
      // load-use on r5 via Y: one stall cycle, then stage 2; consumer writes r9
      vecs.push_back(mk(L, H, 5'd5,  5'd0,  L, L, H, H, L, L, L, H,   L, L, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, H, 5'd9,  5'd5,  H, H, H, L, L, L, L, H,   H, L, 2'd0, 2'd0, L, H));
      vecs.push_back(mk(L, H, 5'd9,  5'd5,  H, H, H, L, L, L, L, H,   L, L, 2'd0, 2'd2, L, H));
      vecs.push_back(mk(L, H, 5'd9,  5'd5,  H, H, L, L, L, L, L, H,   L, L, 2'd1, 2'd0, L, H));
      vecs.push_back(mk(L, L, 5'd0,  5'd0,  L, L, L, L, L, L, L, H,   L, L, 2'd0, 2'd0, L, H));
      vecs.push_back(mk(L, L, 5'd0,  5'd0,  L, L, L, L, L, L, L, H,   L, L, 2'd0, 2'd0, L, L));
      // double writer on r7: the youngest wins
      vecs.push_back(mk(L, H, 5'd7,  5'd0,  L, L, H, L, L, L, L, H,   L, L, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, H, 5'd7,  5'd0,  H, L, H, L, L, L, L, H,   L, L, 2'd1, 2'd0, L, H));
      vecs.push_back(mk(L, H, 5'd7,  5'd7,  H, H, L, L, L, L, L, H,   L, L, 2'd1, 2'd1, L, H));
      vecs.push_back(mk(L, H, 5'd7,  5'd7,  H, H, L, L, L, L, L, H,   L, L, 2'd2, 2'd2, L, H));
      vecs.push_back(mk(L, H, 5'd7,  5'd7,  H, H, L, L, L, L, L, H,   L, L, 2'd0, 2'd0, L, L));
      // taken branch over a pending load-use on r4: 3 flush cycles, no stall, no issue
      vecs.push_back(mk(L, H, 5'd4,  5'd0,  L, L, H, H, L, L, L, H,   L, L, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, H, 5'd4,  5'd0,  H, L, H, L, H, L, L, H,   L, H, 2'd0, 2'd0, L, H));
      vecs.push_back(mk(L, H, 5'd4,  5'd0,  H, L, H, L, L, L, L, H,   L, H, 2'd2, 2'd0, L, H));
      vecs.push_back(mk(L, H, 5'd4,  5'd0,  H, L, H, L, L, L, L, H,   L, H, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, L, 5'd0,  5'd0,  L, L, L, L, L, L, L, H,   L, L, 2'd0, 2'd0, L, L));
      // second branch inside the shadow reloads the counter
      vecs.push_back(mk(L, L, 5'd0,  5'd0,  L, L, L, L, H, L, L, H,   L, H, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, L, 5'd0,  5'd0,  L, L, L, L, H, L, L, H,   L, H, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, L, 5'd0,  5'd0,  L, L, L, L, L, L, L, H,   L, H, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, L, 5'd0,  5'd0,  L, L, L, L, L, L, L, H,   L, H, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, L, 5'd0,  5'd0,  L, L, L, L, L, L, L, H,   L, L, 2'd0, 2'd0, L, L));
      // interrupt with two writes in flight; the request drops during drain
      vecs.push_back(mk(L, H, 5'd1,  5'd0,  L, L, H, L, L, L, H, H,   L, L, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, H, 5'd2,  5'd0,  L, L, H, L, L, H, H, H,   L, L, 2'd0, 2'd0, L, H));
      vecs.push_back(mk(L, H, 5'd3,  5'd0,  L, L, H, L, L, L, H, H,   H, L, 2'd0, 2'd0, L, H));
      vecs.push_back(mk(L, H, 5'd3,  5'd0,  L, L, H, L, L, L, H, H,   H, L, 2'd0, 2'd0, L, H));
      vecs.push_back(mk(L, H, 5'd3,  5'd0,  L, L, H, L, L, L, H, H,   H, L, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, H, 5'd3,  5'd0,  L, L, H, L, L, L, H, H,   L, L, 2'd0, 2'd0, H, L));
      vecs.push_back(mk(L, L, 5'd0,  5'd0,  L, L, L, L, L, L, H, H,   L, L, 2'd0, 2'd0, L, H));
      vecs.push_back(mk(L, L, 5'd0,  5'd0,  L, L, L, L, L, L, H, H,   L, L, 2'd0, 2'd0, L, H));
      vecs.push_back(mk(L, L, 5'd0,  5'd0,  L, L, L, L, L, L, H, H,   L, L, 2'd0, 2'd0, L, L));
      // reset during drain and flush clears everything on the same edge
      vecs.push_back(mk(L, H, 5'd1,  5'd0,  L, L, H, L, L, H, H, H,   L, L, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, L, 5'd0,  5'd0,  L, L, L, L, H, L, H, H,   L, H, 2'd0, 2'd0, L, H));
      vecs.push_back(mk(H, L, 5'd0,  5'd0,  L, L, L, L, L, L, H, H,   L, H, 2'd0, 2'd0, L, H));
      vecs.push_back(mk(L, H, 5'd0,  5'd0,  L, L, L, L, L, L, H, H,   L, L, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(L, H, 5'd0,  5'd0,  L, L, L, L, L, L, H, H,   L, L, 2'd0, 2'd0, L, L));
      // reset during a load-use stall on r8
      vecs.push_back(mk(L, H, 5'd8,  5'd0,  L, L, H, H, L, L, L, H,   L, L, 2'd0, 2'd0, L, L));
      vecs.push_back(mk(H, H, 5'd0,  5'd8,  L, H, L, L, L, L, L, H,   H, L, 2'd0, 2'd0, L, H));
      vecs.push_back(mk(L, H, 5'd0,  5'd8,  L, H, L, L, L, L, L, H,   L, L, 2'd0, 2'd0, L, L));

      @(posedge CLK);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], i);
      end

      // Empty pipeline: INTR_TAKE must rise 2 cycles after the request.
      drive_idle();
      INTR_REQ = H;
      INTR_EN  = H;
      lat_q.push_back(2);
      n = 0;
      @(negedge CLK);
      chk("intr_take_at_req", 0, 8'(INTR_TAKE), 8'd0);
      while (n < 8 && INTR_TAKE !== 1'b1) begin
         @(posedge CLK);
         #1;
         INTR_REQ = L;
         n++;
         @(negedge CLK);
      end
      lat_exp = lat_q.pop_front();
      chk("intr_latency", 0, 8'(n), 8'(lat_exp));
      @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("intr_pulse_width", 0, 8'(INTR_TAKE), 8'd0);
      @(posedge CLK);
      #1;

      // Enable dropped during drain: back to idle, no pulse ever.
      ID_VALID = H; ID_RF_WR = H; ID_ADDRX = 5'd1; INTR_REQ = H; INTR_EN = H;
      @(posedge CLK);
      #1;
      ID_RF_WR = L; INTR_REQ = L; INTR_EN = L;
      @(negedge CLK);
      chk("intr_drop_drain_stall", 0, 8'(STALL), 8'd1);
      chk("intr_drop_drain_busy",  0, 8'(BUSY),  8'd1);
      @(posedge CLK);
      #1;
      ID_VALID = L;
      INTR_EN  = H;
      pulses   = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge CLK);
         if (INTR_TAKE === 1'b1) pulses++;
         @(posedge CLK);
         #1;
      end
      chk("intr_drop_no_pulse", 0, 8'(pulses), 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
